color_channel_ctrl: RTL and testbench
=====================================

Name: color_channel_ctrl

Overview:
- Sequencer that shares one rotary-encoder counter between three 8-bit colour channels (red, green, blue).
- A push button cycles the active channel.
- Encoder count changes since the last sample are applied only to the active channel, with a step size and saturation at 0 and 255.
- Sits between the encoder block (8-bit wrapping `value`) and the LED/PWM stage.

Parameters:
- STEP, 4: channel increment per encoder count; legal range 1-64.
- DEBOUNCE, 250000: clock cycles the synchronized button must stay stable before it is accepted; minimum 2.
- INIT, 0: reset value of all three channel registers.

Ports:
- clk  input  1  system clock; all logic on the rising edge
- reset  input  1  asynchronous, active-high reset
- enc_value  input  8  encoder count; wraps modulo 256; changes by at most one per cycle
- btn  input  1  raw, asynchronous, bouncing push button; 1 = pressed
- red  output  8  red channel level
- green  output  8  green channel level
- blue  output  8  blue channel level
- sel  output  2  active channel: 0 = red, 1 = green, 2 = blue; never 3
- changed  output  1  one-cycle pulse when any channel register or `sel` updates

Behaviour:
- Reset (async assert, sync release):
  - red/green/blue = INIT, sel = 0, changed = 0.
  - last_value = 0, debounced button = 0, debounce counter = 0, synchronizer flops = 0.
- Button path:
  - 2-flop synchronizer on `btn`.
  - If the synchronized level differs from the debounced level, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE-1, the debounced level takes the new value and the counter clears.
  - A 0->1 transition of the debounced level is a press event; release produces no event.
- Select FSM, states SEL_R(0), SEL_G(1), SEL_B(2):
  - Each press advances R->G->B->R.
  - `sel` is the registered state; it changes the cycle after the press event.
- Delta:
  - delta = enc_value - last_value, modulo 256, interpreted as signed 8-bit.
  - last_value <= enc_value every cycle.
  - Wrap 255->0 gives delta +1; 0->255 gives delta -1.
- Channel update when delta != 0:
  - sum = ch + delta*STEP, computed in 16-bit signed.
  - Clamp: sum < 0 gives 0; sum > 255 gives 255; otherwise the low 8 bits.
  - Only the channel selected by the current `sel` is written; the other two hold.
  - Result is visible one cycle after enc_value changes.
- Simultaneous press event and nonzero delta in the same cycle:
  - The delta is applied to the old `sel` channel.
  - `sel` advances in the same edge.
- changed:
  - Asserted for one cycle when `sel` advances or a channel value actually changes.
  - Not asserted when a clamp leaves the value unchanged, e.g. red already 255 and delta +1.
- Reset mid-debounce: the counter and debounced level clear; no press event is generated on release of reset, even if btn is held.

Test Plan:
1. Reset with INIT=0, STEP=4, DEBOUNCE=4 -> red=green=blue=0, sel=0, changed=0; hold btn=1 through reset release -> no sel change until btn goes 0, stays stable, then returns to 1.
2. sel=0, enc_value stepped 0->1->2->3 one per cycle -> red 4, 8, 12 (one cycle after each step); green=blue=0; changed pulses 3 times.
3. Clean press held 6 cycles -> sel 0->1 exactly once, 2+4 cycles after the btn rise; bounce pattern 1,0,1,0 then steady 1 -> exactly one advance; three presses from sel=2 -> 0, 1, 2.
4. sel=1, green=252, enc_value +1 -> green=255; further +1 -> green stays 255 with changed=0; enc_value 0->255 (wrap) from green=2 -> green=0.
5. Press event and enc_value 10->11 in the same cycle with sel=0, red=20 -> red=24, green unchanged, sel=1 next cycle.
6. Assert reset while the debounce counter is at 2 and red=100 -> all outputs return to reset values immediately (async), no spurious sel advance afterwards.

Source files
------------

// File: rtl/color_channel_ctrl.sv
// Shares one rotary-encoder count between three 8-bit colour channels (red, green, blue).
// A debounced push button rotates the active channel; encoder deltas are scaled and saturated.
module color_channel_ctrl #(
    parameter int unsigned STEP     = 4,
    parameter int unsigned DEBOUNCE = 250000,
    parameter logic [7:0]  INIT     = 8'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] enc_value,
    input  logic       btn,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic [1:0] sel,
    output logic       changed
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        SEL_R = 2'd0,
        SEL_G = 2'd1,
        SEL_B = 2'd2
    } sel_state_e;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db_level;
    logic [CNT_W-1:0] r_db_cnt;
    logic [1:0]       r_fill;
    logic             r_armed;

    sel_state_e       r_state;
    sel_state_e       w_state_next;
    logic             w_sel_adv;

    logic [7:0]       r_red;
    logic [7:0]       r_green;
    logic [7:0]       r_blue;
    logic [7:0]       r_last;
    logic             r_changed;

    logic             w_db_diff;
    logic             w_db_accept;
    logic             w_sync_valid;
    logic             w_press;

    logic [7:0]       w_delta;
    logic             w_delta_nz;
    logic [7:0]       w_cur;
    logic [7:0]       w_new;
    logic             w_ch_write;
    logic signed [15:0] w_cur_s;
    logic signed [15:0] w_delta_s;
    logic signed [15:0] w_step_s;
    logic signed [15:0] w_sum;

    // Button synchronizer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_db_diff   = (r_sync2 != r_db_level);
    assign w_db_accept = w_db_diff && (r_db_cnt == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_db_level <= 1'b0;
            r_db_cnt   <= '0;
        end else if (w_db_accept) begin
            r_db_level <= r_sync2;
            r_db_cnt   <= '0;
        end else if (w_db_diff) begin
            r_db_cnt   <= r_db_cnt + CNT_W'(1);
        end else begin
            r_db_cnt   <= '0;
        end
    end

    // Presses are only honoured once the button has been seen released after reset,
    // so a button held through reset release cannot advance the channel.
    assign w_sync_valid = (r_fill == 2'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fill  <= 2'd0;
            r_armed <= 1'b0;
        end else begin
            if (!w_sync_valid) begin
                r_fill <= r_fill + 2'd1;
            end
            if (w_sync_valid && !r_sync2 && !r_db_level) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_press = w_db_accept && r_sync2 && r_armed;

    // Channel select FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SEL_R;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sel_adv    = 1'b0;
        if (w_press) begin
            w_sel_adv = 1'b1;
            unique case (r_state)
                SEL_R:   w_state_next = SEL_G;
                SEL_G:   w_state_next = SEL_B;
                SEL_B:   w_state_next = SEL_R;
                default: w_state_next = SEL_R;
            endcase
        end
    end

    // Encoder delta, scaled and saturated against the currently selected channel
    assign w_delta    = enc_value - r_last;
    assign w_delta_nz = |w_delta;

    always_comb begin
        w_cur = r_red;
        case (r_state)
            SEL_G:   w_cur = r_green;
            SEL_B:   w_cur = r_blue;
            default: w_cur = r_red;
        endcase
    end

    assign w_cur_s   = {8'd0, w_cur};
    assign w_delta_s = {{8{w_delta[7]}}, w_delta};
    assign w_step_s  = 16'(STEP);
    assign w_sum     = w_cur_s + w_delta_s * w_step_s;

    always_comb begin
        w_new = w_sum[7:0];
        if (w_sum < 16'sd0) begin
            w_new = 8'd0;
        end else if (w_sum > 16'sd255) begin
            w_new = 8'hFF;
        end
    end

    assign w_ch_write = w_delta_nz && (w_new != w_cur);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_red     <= INIT;
            r_green   <= INIT;
            r_blue    <= INIT;
            r_last    <= 8'd0;
            r_changed <= 1'b0;
        end else begin
            r_last    <= enc_value;
            r_changed <= w_ch_write || w_sel_adv;
            if (w_ch_write) begin
                case (r_state)
                    SEL_G:   r_green <= w_new;
                    SEL_B:   r_blue  <= w_new;
                    default: r_red   <= w_new;
                endcase
            end
        end
    end

    assign red     = r_red;
    assign green   = r_green;
    assign blue    = r_blue;
    assign sel     = r_state;
    assign changed = r_changed;

    a_sel_legal : assert property (@(posedge clk) disable iff (reset) r_state != 2'd3);

endmodule

// File: tb/tb_color_channel_ctrl.sv
// Self-checking bench for color_channel_ctrl: scoreboard of expected outputs per clock,
// driven on the falling edge and compared just after the rising edge.
module tb_color_channel_ctrl;

    localparam int unsigned STEP     = 4;
    localparam int unsigned DEBOUNCE = 4;
    localparam logic [7:0]  INIT     = 8'd0;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] enc_value;
    logic       btn;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic [1:0] sel;
    logic       changed;

    always #5 clk = ~clk;

    color_channel_ctrl #(
        .STEP     (STEP),
        .DEBOUNCE (DEBOUNCE),
        .INIT     (INIT)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .enc_value (enc_value),
        .btn       (btn),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .sel       (sel),
        .changed   (changed)
    );

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [1:0] s;
        logic       c;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] m_red, m_green, m_blue, m_last;
    logic [1:0] m_sel;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic chg);
        exp_t e;
        e.r = m_red;
        e.g = m_green;
        e.b = m_blue;
        e.s = m_sel;
        e.c = chg;
        sb_q.push_back(e);
    endtask

    task automatic compare_now(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq({tag, ".sb_empty"}, 0, 1);
            return;
        end
        e = sb_q.pop_front();
        check_eq({tag, ".red"},     int'(red),     int'(e.r));
        check_eq({tag, ".green"},   int'(green),   int'(e.g));
        check_eq({tag, ".blue"},    int'(blue),    int'(e.b));
        check_eq({tag, ".sel"},     int'(sel),     int'(e.s));
        check_eq({tag, ".changed"}, int'(changed), int'(e.c));
    endtask

    task automatic tick_check(input string tag);
        @(posedge clk);
        #1;
        compare_now(tag);
    endtask

    function automatic logic [7:0] sat_step(input logic [7:0] cur, input logic [7:0] d8);
        int d;
        int s;
        d = (d8 >= 8'd128) ? int'(d8) - 256 : int'(d8);
        s = int'(cur) + d * int'(STEP);
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
        return 8'(s);
    endfunction

    task automatic model_enc(input logic [7:0] v, output logic chg);
        logic [7:0] d8, cur, nxt;
        d8     = v - m_last;
        m_last = v;
        chg    = 1'b0;
        if (d8 != 8'd0) begin
            case (m_sel)
                2'd0:    cur = m_red;
                2'd1:    cur = m_green;
                default: cur = m_blue;
            endcase
            nxt = sat_step(cur, d8);
            chg = (nxt != cur);
            case (m_sel)
                2'd0:    m_red   = nxt;
                2'd1:    m_green = nxt;
                default: m_blue  = nxt;
            endcase
        end
    endtask

    task automatic enc_step(input string tag, input logic [7:0] v);
        logic chg;
        @(negedge clk);
        enc_value = v;
        model_enc(v, chg);
        push_exp(chg);
        tick_check(tag);
    endtask

    task automatic idle(input string tag, input int n, input logic b);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            btn = b;
            push_exp(1'b0);
            tick_check(tag);
        end
    endtask

    // Optional alternating 1,0 bounce, then a steady high; the advance lands on the
    // sixth rising edge after the final rise (2 sync flops + DEBOUNCE cycles).
    task automatic press(input string tag, input int bounce_len, input int hold,
                         input int do_enc, input logic [7:0] enc_v);
        int   adv;
        logic chg;
        adv = bounce_len + 2 + int'(DEBOUNCE);
        for (int i = 1; i <= bounce_len + hold; i++) begin
            @(negedge clk);
            btn = (i <= bounce_len) ? (i % 2 == 1) : 1'b1;
            chg = 1'b0;
            if (i == adv) begin
                if (do_enc != 0) begin
                    enc_value = enc_v;
                    model_enc(enc_v, chg);
                end
                m_sel = (m_sel == 2'd2) ? 2'd0 : m_sel + 2'd1;
                chg   = 1'b1;
            end
            push_exp(chg);
            tick_check(tag);
        end
        idle({tag, ".rel"}, 8, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        btn       = 1'b1;
        enc_value = 8'd0;
        m_red     = INIT;
        m_green   = INIT;
        m_blue    = INIT;
        m_last    = 8'd0;
        m_sel     = 2'd0;

        // Reset state, button held through release
        repeat (3) @(posedge clk);
        #1;
        push_exp(1'b0);
        compare_now("reset");
        @(negedge clk);
        reset = 1'b0;
        idle("t1.hold", 10, 1'b1);
        idle("t1.low", 10, 1'b0);
        press("t1.press", 0, 6, 0, 8'd0);
        check_eq("t1.sel_after_press", int'(sel), 1);

        // Saturation and wrap on green
        for (int v = 1; v <= 63; v++) enc_step("t4.up", 8'(v));
        check_eq("t4.green252", int'(green), 252);
        enc_step("t4.sat_hi", 8'd64);
        check_eq("t4.green255", int'(green), 255);
        enc_step("t4.sat_hold", 8'd65);
        check_eq("t4.sat_no_changed", int'(changed), 0);
        for (int v = 64; v >= 1; v--) enc_step("t4.down", 8'(v));
        enc_step("t4.sat_lo", 8'd0);
        enc_step("t4.wrap_dn_clamp", 8'd255);
        enc_step("t4.wrap_up", 8'd0);
        check_eq("t4.wrap_plus1", int'(green), 4);
        enc_step("t4.wrap_dn", 8'd255);
        check_eq("t4.wrap_minus1", int'(green), 0);
        enc_step("t4.clamp0", 8'd254);

        // Clean and bouncing presses
        press("t3.clean", 0, 6, 0, 8'd0);
        check_eq("t3.sel2", int'(sel), 2);
        press("t3.bounce", 4, 6, 0, 8'd0);
        check_eq("t3.sel0", int'(sel), 0);

        // Red increments
        enc_step("t2.s1", 8'd255);
        check_eq("t2.red4", int'(red), 4);
        enc_step("t2.s2", 8'd0);
        check_eq("t2.red8", int'(red), 8);
        enc_step("t2.s3", 8'd1);
        check_eq("t2.red12", int'(red), 12);
        check_eq("t2.blue0", int'(blue), 0);

        // Press and delta in the same cycle
        enc_step("t5.pre1", 8'd2);
        enc_step("t5.pre2", 8'd3);
        check_eq("t5.red20", int'(red), 20);
        press("t5.both", 0, 6, 1, 8'd4);
        check_eq("t5.red24", int'(red), 24);
        check_eq("t5.sel1", int'(sel), 1);

        // Full rotation from blue
        press("t3.to2", 0, 6, 0, 8'd0);
        press("t3.r0", 0, 6, 0, 8'd0);
        check_eq("t3.rot0", int'(sel), 0);
        press("t3.r1", 0, 6, 0, 8'd0);
        check_eq("t3.rot1", int'(sel), 1);
        press("t3.r2", 0, 6, 0, 8'd0);
        check_eq("t3.rot2", int'(sel), 2);

        // Async reset mid-debounce (counter at 2 after four edges of held button)
        idle("t6.pre", 4, 1'b1);
        #2;
        reset     = 1'b1;
        enc_value = 8'd0;
        #1;
        check_eq("t6.async_red",     int'(red),     0);
        check_eq("t6.async_green",   int'(green),   0);
        check_eq("t6.async_blue",    int'(blue),    0);
        check_eq("t6.async_sel",     int'(sel),     0);
        check_eq("t6.async_changed", int'(changed), 0);
        m_red   = INIT;
        m_green = INIT;
        m_blue  = INIT;
        m_last  = 8'd0;
        m_sel   = 2'd0;
        @(negedge clk);
        reset = 1'b0;
        idle("t6.hold", 10, 1'b1);
        idle("t6.rel", 10, 1'b0);

        check_eq("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
